// File: rtl/pipe_addsub_cin.sv
// Pipelined add/subtract with carry/borrow-in; carry chain split into CHUNK-bit stages.
// Define PIPE_ADDSUB_CIN_OVF_EN to add the OVF signed-overflow output.
module pipe_addsub_cin #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             CIN,
   input  logic             SUB,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   output logic [WIDTH-1:0] O,
   output logic             COUT,
   output logic             VALID_OUT,
   input  logic             READY_IN
`ifdef PIPE_ADDSUB_CIN_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int STAGES = WIDTH / CHUNK;

   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
   logic [STAGES-1:0]            c_q, c_d;
   logic [STAGES-1:0]            v_q, v_d;

   logic             adv;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] s_in;
   logic             c_in;
   logic             v_in;
   logic [CHUNK:0]   sl;
   logic             ovf_d;

   // Operands travel with their slot; stage k only resolves slice k.
   always_comb begin
      adv   = READY_IN | ~v_q[STAGES-1];
      a_d   = a_q;
      b_d   = b_q;
      s_d   = s_q;
      c_d   = c_q;
      v_d   = v_q;
      a_in  = '0;
      b_in  = '0;
      s_in  = '0;
      c_in  = 1'b0;
      v_in  = 1'b0;
      sl    = '0;
      ovf_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            a_in = I0;
            b_in = SUB ? ~I1 : I1;
            s_in = '0;
            c_in = SUB ? ~CIN : CIN;
            v_in = VALID_IN;
         end else begin
            a_in = a_q[(k > 0) ? k-1 : 0];
            b_in = b_q[(k > 0) ? k-1 : 0];
            s_in = s_q[(k > 0) ? k-1 : 0];
            c_in = c_q[(k > 0) ? k-1 : 0];
            v_in = v_q[(k > 0) ? k-1 : 0];
         end
         sl = {1'b0, a_in[k*CHUNK +: CHUNK]}
            + {1'b0, b_in[k*CHUNK +: CHUNK]}
            + (CHUNK+1)'(c_in);
         s_in[k*CHUNK +: CHUNK] = sl[CHUNK-1:0];
         a_d[k] = a_in;
         b_d[k] = b_in;
         s_d[k] = s_in;
         c_d[k] = sl[CHUNK];
         v_d[k] = v_in;
      end
      // Same-sign operands giving an opposite-sign sum == carry-in(MSB) ^ carry-out.
      ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1])
            & (s_in[WIDTH-1] != a_in[WIDTH-1]);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         c_q <= '0;
         v_q <= '0;
      end else if (adv) begin
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

`ifdef PIPE_ADDSUB_CIN_OVF_EN
   logic ovf_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign OVF = ovf_q;
   logic unused_last;
   assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1]};
`else
   logic unused_last;
   assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], ovf_d};
`endif

   assign READY_OUT = adv & ~RESET;
   assign O         = s_q[STAGES-1];
   assign COUT      = c_q[STAGES-1];
   assign VALID_OUT = v_q[STAGES-1];

endmodule
